// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ADD/SUB, WIDTH-iteration shift-add MUL,
// result and flags held under a valid/ready handshake until consumed.
module alu_exec #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluCtrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q,    ovf_d;
    logic             ill_q,    ill_d;

    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] mul_sum;

    assign add_res = src_a + src_b;
    assign sub_res = src_a - src_b;
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (aluCtrl)
                        OP_ADD: begin
                            result_d = add_res;
                            ovf_d    = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                                       (add_res[WIDTH-1] != src_a[WIDTH-1]);
                            ill_d    = 1'b0;
                            state_d  = S_DONE;
                        end
                        OP_SUB: begin
                            result_d = sub_res;
                            ovf_d    = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                                       (sub_res[WIDTH-1] != src_a[WIDTH-1]);
                            ill_d    = 1'b0;
                            state_d  = S_DONE;
                        end
                        OP_MUL: begin
                            mcand_d  = src_a;
                            mplier_d = src_b;
                            acc_d    = '0;
                            count_d  = CW'(WIDTH);
                            ill_d    = 1'b0;
                            state_d  = S_MUL;
                        end
                        default: begin
                            result_d = '0;
                            ovf_d    = 1'b0;
                            ill_d    = 1'b1;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CW'(1);
                // Last iteration publishes the freshly summed accumulator directly.
                if (count_q == CW'(1)) begin
                    result_d = mul_sum;
                    ovf_d    = 1'b0;
                    ill_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU that consumes the 2-bit `aluCtrl` code produced by decode, together with two operands, and returns a registered result with flags. ADD and SUB complete in one cycle. MUL runs as a WIDTH-iteration shift-add sequence. Results are held under a valid/ready handshake so the execute/memory boundary can stall the unit.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request present.
- `in_ready`  out  1  unit can accept a request; high only in IDLE.
- `aluCtrl`  in  2  operation code: 00 ADD, 01 SUB, 10 MUL, 11 illegal.
- `src_a`  in  WIDTH  first operand.
- `src_b`  in  WIDTH  second operand.
- `out_valid`  out  1  result/flags valid; high only in DONE.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `result == 0`.
- `overflow`  out  1  signed overflow, ADD/SUB only.
- `illegal`  out  1  request carried code 11.

## Operation
- States: IDLE, MUL, DONE.
- Accept happens when `in_valid && in_ready` on a rising edge. `aluCtrl`, `src_a` and `src_b` are sampled only at accept.
- **IDLE, accept:**
  - ADD: `result = src_a + src_b` mod 2^WIDTH. `overflow` = operand signs equal and result sign differs. Go to DONE.
  - SUB: `result = src_a - src_b` mod 2^WIDTH. `overflow` = operand signs differ and result sign differs from `src_a`. Go to DONE.
  - MUL: load `mcand = src_a`, `mplier = src_b`, `acc = 0`, `count = WIDTH`. Go to MUL.
  - 11: `result = 0`, `illegal = 1`, `overflow = 0`. Go to DONE.
- **MUL, each edge:**
  - If `mplier[0]`: `acc += mcand` (WIDTH bits, carry discarded).
  - Then `mcand <<= 1`, `mplier >>= 1`, `count -= 1`.
  - On the edge where `count` goes 1 → 0: `result` takes the final `acc`, `overflow = 0`, `illegal = 0`, go to DONE.
  - `result` is the unsigned product mod 2^WIDTH, which equals the low WIDTH bits of the two's-complement product.
- **DONE:** `out_valid = 1`, `in_ready = 0`. `result`, `zero`, `overflow` and `illegal` hold stable while `out_ready` is low. When `out_ready` is high on an edge, go to IDLE.
- `zero` is derived from the registered `result` and is valid whenever `out_valid` is high.
- `illegal` clears on every non-11 accept. `overflow` is rewritten on every completion.
- `in_valid` and operand changes outside IDLE are ignored. No request is queued.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready = 1`, `out_valid = 0`.
  - `result = 0`, `zero = 1`, `overflow = 0`, `illegal = 0`.
  - `count = 0`, `acc = 0`.
- Reset asserted mid-MUL or in DONE aborts immediately. The pending result is lost. The first accept is possible on the first edge after reset deasserts.
- With accept in cycle N:
  - ADD, SUB, 11: `out_valid` high from cycle N+1.
  - MUL: `out_valid` high from cycle N+1+WIDTH. `in_ready` is low during cycles N+1 … N+WIDTH.
- DONE lasts at least one cycle. With `out_ready` tied high, the peak rate is one ADD/SUB every 2 cycles and one MUL every WIDTH+2 cycles.
- `in_ready` and `out_valid` are decoded from state only. They have no combinational path from `in_valid` or `out_ready`.

## Test plan
- **Reset and ADD:** apply reset, then ADD 0x7FFFFFFF + 0x00000001 with `out_ready = 1`. Required: `result = 0x80000000`, `overflow = 1`, `zero = 0`, `out_valid` high exactly one cycle after accept.
- **SUB to zero:** SUB 0x00000005 − 0x00000005. Required: `result = 0`, `zero = 1`, `overflow = 0`. Then SUB 0x80000000 − 1. Required: `result = 0x7FFFFFFF`, `overflow = 1`.
- **MUL latency:** MUL 0x00001234 × 0x00000010. Required: `result = 0x00012340`, `out_valid` first high 33 cycles after accept, `in_ready = 0` throughout. Then MUL 0xFFFFFFFF × 0xFFFFFFFF. Required: `result = 0x00000001`, `overflow = 0`.
- **Backpressure:** complete an ADD and hold `out_ready = 0` for 10 cycles while toggling `in_valid` and operands. Required: `result` and flags stable, no new accept. When `out_ready` rises, return to IDLE next cycle.
- **Illegal code:** `aluCtrl = 11` with any operands. Required: `result = 0`, `illegal = 1`, `zero = 1`. A following ADD 2 + 3 gives `result = 5` and `illegal = 0`.
- **Reset mid-MUL:** assert reset 10 cycles into a MUL. Required: all outputs at reset values immediately. A fresh ADD 1 + 1 after release returns 2 with no residue from `acc`.
